// File: rtl/difftest_axis_packer_if.sv
// rtl/difftest_axis_packer_if.sv - AXI-Stream beat bundle between the packer and the XDMA AXI stage
//
// Purpose: groups the stream handshake and payload of one AXI-Stream link.
// Signals:
//   tdata   AXIS_DATA_WIDTH    beat payload
//   tkeep   AXIS_DATA_WIDTH/8  byte-valid mask
//   tlast   1                  last beat of a packet
//   tvalid  1                  beat valid
//   tready  1                  downstream accepts the beat
// Modports: master (drives payload/valid, samples ready), slave (the reverse).

interface difftest_axis_packer_if #(
  parameter int AXIS_DATA_WIDTH = 512
);
  logic [AXIS_DATA_WIDTH-1:0]   tdata;
  logic [AXIS_DATA_WIDTH/8-1:0] tkeep;
  logic                         tlast;
  logic                         tvalid;
  logic                         tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/difftest_axis_packer.sv
// rtl/difftest_axis_packer.sv - difftest batch word FIFO and AXI-Stream serializer
//
// Purpose: captures one DATA_WIDTH-bit batch word per enabled core step into a
// FIFO_DEPTH-entry FIFO and emits each word as a packet of AXIS_DATA_WIDTH-bit
// beats. core_clock_enable freezes the core whenever the FIFO would overflow,
// so no batch word is ever dropped.
// Optional feature macro: DIFFTEST_AXIS_PACKET_HEADER_EN prepends one header
// beat per packet ({NUM_BEATS[15:0], seq[31:0]} zero-extended).
// Ports:
//   clock              in   single clock, rising edge
//   reset              in   synchronous, active-high
//   difftest_data      in   DATA_WIDTH batch word from the core
//   difftest_enable    in   difftest_data valid this cycle
//   core_clock_enable  out  core may advance this cycle (registered)
//   axi                master AXI-Stream link (tdata/tkeep/tlast/tvalid/tready)

module difftest_axis_packer #(
  parameter int DATA_WIDTH      = 4096,
  parameter int AXIS_DATA_WIDTH = 512,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        difftest_data,
  input  logic                         difftest_enable,
  output logic                         core_clock_enable,
  difftest_axis_packer_if.master       axi
);

  localparam int NUM_BEATS  = (DATA_WIDTH + AXIS_DATA_WIDTH - 1) / AXIS_DATA_WIDTH;
  localparam int LAST_BYTES = (DATA_WIDTH - (NUM_BEATS - 1) * AXIS_DATA_WIDTH) / 8;
  localparam int KEEP_W     = AXIS_DATA_WIDTH / 8;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = PTR_W + 1;
  localparam int PAD_W      = NUM_BEATS * AXIS_DATA_WIDTH;
`ifdef DIFFTEST_AXIS_PACKET_HEADER_EN
  localparam int HDR_BEATS  = 1;
`else
  localparam int HDR_BEATS  = 0;
`endif
  localparam int PKT_BEATS  = NUM_BEATS + HDR_BEATS;
  localparam int IDX_W      = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(PKT_BEATS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C       = CNT_W'(FIFO_DEPTH);
  // One spare bit so LAST_BYTES == KEEP_W still yields an all-ones mask.
  localparam logic [KEEP_W:0]   LAST_KEEP_EXT = ((KEEP_W + 1)'(1) << LAST_BYTES) - (KEEP_W + 1)'(1);
  localparam logic [KEEP_W-1:0] LAST_KEEP     = LAST_KEEP_EXT[KEEP_W-1:0];

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [IDX_W-1:0]      beat_idx;
  logic                  ce_q;

  logic                  push;
  logic                  pop;
  logic                  beat_fire;
  logic                  last_beat;
  logic                  head_valid;
  logic [CNT_W-1:0]      count_next;
  logic [IDX_W-1:0]      pay_idx;
  logic [PAD_W-1:0]      padded;
  logic [AXIS_DATA_WIDTH-1:0] payload_beat;

  // The core is frozen while ce_q is low, so its enable is only meaningful when ce_q is high.
  assign push       = difftest_enable && ce_q;
  assign head_valid = (count != '0);
  assign last_beat  = (beat_idx == LAST_IDX);
  assign beat_fire  = head_valid && axi.tready;
  assign pop        = beat_fire && last_beat;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

`ifdef DIFFTEST_AXIS_PACKET_HEADER_EN
  logic [31:0] seq_num;

  // Payload beat k sits at beat_idx k+1; the value at beat_idx 0 is unused.
  assign pay_idx = beat_idx - IDX_W'(1);
`else
  assign pay_idx = beat_idx;
`endif

  // Zero-extend the head word so the final beat is padded above DATA_WIDTH.
  assign padded       = PAD_W'(mem[rd_ptr]);
  assign payload_beat = AXIS_DATA_WIDTH'(padded >> (int'(pay_idx) * AXIS_DATA_WIDTH));

  always_comb begin
    axi.tvalid = head_valid;
    axi.tlast  = head_valid && last_beat;
    axi.tkeep  = last_beat ? LAST_KEEP : '1;
    axi.tdata  = payload_beat;
`ifdef DIFFTEST_AXIS_PACKET_HEADER_EN
    if (beat_idx == '0) begin
      axi.tdata = AXIS_DATA_WIDTH'({16'(NUM_BEATS), seq_num});
    end
`endif
  end

  assign core_clock_enable = ce_q;

  // Storage carries no reset; only pointers and occupancy decide what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= difftest_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      beat_idx <= '0;
      ce_q     <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (beat_fire) begin
        beat_idx <= last_beat ? '0 : beat_idx + IDX_W'(1);
      end
      count <= count_next;
      // Looking at post-update occupancy keeps any push made while ce_q is high legal.
      ce_q  <= (count_next < DEPTH_C);
    end
  end

`ifdef DIFFTEST_AXIS_PACKET_HEADER_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      seq_num <= '0;
    end else if (pop) begin
      seq_num <= seq_num + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_difftest_axis_packer.sv
// tb/tb_difftest_axis_packer.sv - self-checking bench for difftest_axis_packer

module tb_difftest_axis_packer;

  localparam int DW    = 1200;
  localparam int AW    = 512;
  localparam int KW    = AW / 8;
  localparam int DEPTH = 4;
  localparam int NB    = 3;
`ifdef DIFFTEST_AXIS_PACKET_HEADER_EN
  localparam int HB    = 1;
`else
  localparam int HB    = 0;
`endif
  localparam int PB    = NB + HB;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] difftest_data;
  logic          difftest_enable;
  logic          core_clock_enable;

  difftest_axis_packer_if #(.AXIS_DATA_WIDTH(AW)) axi ();

  difftest_axis_packer #(
    .DATA_WIDTH(DW),
    .AXIS_DATA_WIDTH(AW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .difftest_data(difftest_data),
    .difftest_enable(difftest_enable),
    .core_clock_enable(core_clock_enable),
    .axi(axi)
  );

  always #5 clock = ~clock;

  // Reference model: queue of accepted words, position within the head packet,
  // enable derived from queue occupancy, packet sequence number.
  logic [DW-1:0] mq[$];
  int            m_beat = 0;
  bit            m_ce   = 1'b1;
  logic [31:0]   m_seq  = '0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < 38; i++) w = {w[DW-33:0], 32'($urandom)};
    return w;
  endfunction

  task automatic check_outputs(input string ph);
    logic [DW-1:0] sh;
    logic [AW-1:0] exp_data;
    logic [KW-1:0] exp_keep;
    chk({ph, "_ce"}, AW'(core_clock_enable), AW'(m_ce));
    chk({ph, "_tvalid"}, AW'(axi.tvalid), AW'(mq.size() != 0));
    if (mq.size() != 0) begin
      if (HB == 1 && m_beat == 0) begin
        exp_data = AW'({16'd3, m_seq});
      end else begin
        sh       = mq[0] >> ((m_beat - HB) * AW);
        exp_data = sh[AW-1:0];
      end
      exp_keep = (m_beat == PB - 1) ? KW'(22'h3FFFFF) : '1;
      chk({ph, "_tdata"}, axi.tdata, exp_data);
      chk({ph, "_tkeep"}, AW'(axi.tkeep), AW'(exp_keep));
      chk({ph, "_tlast"}, AW'(axi.tlast), AW'(m_beat == PB - 1));
    end else begin
      chk({ph, "_tlast_idle"}, AW'(axi.tlast), '0);
    end
  endtask

  // One clock cycle: drive inputs and check at the falling edge, advance the model at the rising edge.
  task automatic step(input string ph, input bit en, input bit rdy, input bit rst);
    bit done;
    difftest_enable = en;
    difftest_data   = rand_word();
    axi.tready      = rdy;
    reset           = rst;
    check_outputs(ph);
    @(posedge clock);
    if (rst) begin
      mq.delete();
      m_beat = 0;
      m_ce   = 1'b1;
      m_seq  = '0;
    end else begin
      done = 1'b0;
      if (mq.size() != 0 && rdy) begin
        done   = (m_beat == PB - 1);
        m_beat = done ? 0 : m_beat + 1;
      end
      if (done) begin
        void'(mq.pop_front());
        m_seq = m_seq + 32'd1;
      end
      if (en && m_ce) mq.push_back(difftest_data);
      m_ce = (mq.size() < DEPTH);
    end
    @(negedge clock);
  endtask

  int drained;

  initial begin
    reset           = 1'b1;
    difftest_enable = 1'b0;
    difftest_data   = '0;
    axi.tready      = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);

    // Reset state, then one word drained with tready high.
    step("rst", 1'b0, 1'b0, 1'b1);
    step("idle", 1'b0, 1'b0, 1'b0);
    step("single_push", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step("single", 1'b0, 1'b1, 1'b0);

    // Fill with tready low: only four words get in, then the core is frozen.
    for (int i = 0; i < 10; i++) step("fill", 1'b1, 1'b0, 1'b0);
    chk("fill_ce_low", AW'(core_clock_enable), '0);
    drained = 0;
    for (int i = 0; i < 12; i++) begin
      if (axi.tvalid) drained++;
      step("drain", 1'b0, 1'b1, 1'b0);
    end
    chk("drain_beats", AW'(drained), AW'(12));
    step("drain_empty", 1'b0, 1'b1, 1'b0);

    // tready toggling during packets.
    step("tog_push", 1'b1, 1'b0, 1'b0);
    step("tog_push", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step("toggle", 1'b0, (i % 2) == 0, 1'b0);

    // Full FIFO: pop of the last beat reopens the enable; push and pop coincide afterwards.
    for (int i = 0; i < 6; i++) step("full", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) step("pushpop", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step("pushpop_drain", 1'b0, 1'b1, 1'b0);

    // Reset after the first beat of a packet discards the rest.
    step("mid_push", 1'b1, 1'b0, 1'b0);
    step("mid_beat0", 1'b0, 1'b1, 1'b0);
    step("mid_rst", 1'b0, 1'b0, 1'b1);
    chk("mid_tvalid", AW'(axi.tvalid), '0);
    chk("mid_ce", AW'(core_clock_enable), AW'(1));
    step("mid_after", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step("mid_next", 1'b0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom % 3) != 0, ($urandom % 4) != 0, 1'b0);
    end
    for (int i = 0; i < 24; i++) step("rand_drain", 1'b0, 1'b1, 1'b0);

`ifdef DIFFTEST_AXIS_PACKET_HEADER_EN
    // Sequence wrap: preload the counter just below wrap and send two packets.
    step("seq_rst", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("hdr3", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 14; i++) step("hdr3_drain", 1'b0, 1'b1, 1'b0);
    dut.seq_num = 32'hFFFF_FFFF;
    m_seq       = 32'hFFFF_FFFF;
    step("wrap_push", 1'b1, 1'b1, 1'b0);
    step("wrap_push", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step("wrap", 1'b0, 1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
